pwm_duty_ctrl: RTL

PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

---
 rtl/pwm_duty_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pwm_duty_ctrl.sv
// Button-driven PWM duty controller: synchronised inc/dec presses move a saturating target.
// Define PWM_DUTY_RAMP_EN to slew duty toward target 1 LSB every RAMP_DIV cycles; otherwise duty follows target.
module pwm_duty_ctrl #(
  parameter int DUTY_INIT = 50,
  parameter int DUTY_MAX  = 100,
  parameter int STEP      = 10,
  parameter int RAMP_DIV  = 4
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       inc_n,
  input  logic       dec_n,
  output logic [7:0] duty,
  output logic       busy,
  output logic       at_max,
  output logic       at_min
);

  localparam logic [8:0] C_STEP9 = 9'(STEP);
  localparam logic [8:0] C_MAX9  = 9'(DUTY_MAX);
  localparam logic [7:0] C_MAX8  = 8'(DUTY_MAX);
  localparam logic [7:0] C_STEP8 = 8'(STEP);
  localparam logic [7:0] C_INIT8 = 8'(DUTY_INIT);

  logic       r_inc_s1, r_inc_s2, r_inc_h;
  logic       r_dec_s1, r_dec_s2, r_dec_h;
  logic [7:0] r_target;
  logic [7:0] r_duty;
  logic       w_inc_req, w_dec_req;
  logic [8:0] w_sum;
  logic [7:0] w_target_nxt;

  // Two-flop synchronisers plus a history flop for falling-edge detection.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      {r_inc_s1, r_inc_s2, r_inc_h} <= 3'b111;
      {r_dec_s1, r_dec_s2, r_dec_h} <= 3'b111;
    end else begin
      {r_inc_s1, r_inc_s2, r_inc_h} <= {inc_n, r_inc_s1, r_inc_s2};
      {r_dec_s1, r_dec_s2, r_dec_h} <= {dec_n, r_dec_s1, r_dec_s2};
    end
  end

  assign w_inc_req = r_inc_h & ~r_inc_s2;
  assign w_dec_req = r_dec_h & ~r_dec_s2;

  // Next target: saturating add/subtract; simultaneous requests cancel.
  always_comb begin
    w_sum        = {1'b0, r_target} + C_STEP9;
    w_target_nxt = r_target;
    if (w_inc_req && !w_dec_req) begin
      if (w_sum > C_MAX9) w_target_nxt = C_MAX8;
      else                w_target_nxt = w_sum[7:0];
    end else if (w_dec_req && !w_inc_req) begin
      if ({1'b0, r_target} < C_STEP9) w_target_nxt = 8'd0;
      else                            w_target_nxt = r_target - C_STEP8;
    end else begin
      w_target_nxt = r_target;
    end
  end

  // Target register.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) r_target <= C_INIT8;
    else        r_target <= w_target_nxt;
  end

`ifdef PWM_DUTY_RAMP_EN
  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(RAMP_DIV - 1);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;

  // Ramp FSM; step direction is re-evaluated against the live target at every step.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_duty  <= C_INIT8;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_duty != r_target) begin
            r_state <= RAMP;
            r_cnt   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        RAMP: begin
          if (r_duty == r_target) begin
            r_state <= IDLE;
          end else if (r_cnt == C_CNT_LAST) begin
            r_cnt <= '0;
            if (r_duty < r_target) r_duty <= r_duty + 8'd1;
            else                   r_duty <= r_duty - 8'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (r_duty != r_target);
`else
  // Without ramping, duty tracks the target on the same edge it updates.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) r_duty <= C_INIT8;
    else        r_duty <= w_target_nxt;
  end

  assign busy = 1'b0;
`endif

  assign duty   = r_duty;
  assign at_max = (r_target == C_MAX8);
  assign at_min = (r_target == 8'd0);

endmodule
